// File: rtl/comp_seq_if.sv
// Request/result bundle for the sequential magnitude comparator: start/sgn/a/b in,
// busy/done/gt/eq/lt back.
interface comp_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, sgn, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/comp_seq.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, signed or unsigned.
// Define COMP_SEQ_EARLY_TERM_EN to finish on the first differing chunk.
module comp_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  comp_seq_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  IDX_LAST  = IDXW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);

`ifdef COMP_SEQ_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  typedef enum logic [1:0] {
    DEC_NONE = 2'b00,
    DEC_GT   = 2'b01,
    DEC_LT   = 2'b10
  } dec_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  dec_t             r_dec;
  logic             r_busy;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [IDXW-1:0]  w_idx_nxt;
  dec_t             w_dec_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_gt_nxt;
  logic             w_eq_nxt;
  logic             w_lt_nxt;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  dec_t             w_dec_step;
  logic             w_finish;

  // Select the current chunk and fold it into the sticky decision.
  always_comb begin
    w_a_sh    = r_a >> (CHUNK * r_idx);
    w_b_sh    = r_b >> (CHUNK * r_idx);
    w_a_chunk = w_a_sh[CHUNK-1:0];
    w_b_chunk = w_b_sh[CHUNK-1:0];
    w_dec_step = r_dec;
    if (r_dec == DEC_NONE) begin
      if (w_a_chunk > w_b_chunk) begin
        w_dec_step = DEC_GT;
      end else if (w_a_chunk < w_b_chunk) begin
        w_dec_step = DEC_LT;
      end
    end
    w_finish = (r_idx == '0) || (EARLY_TERM && (w_dec_step != DEC_NONE));
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_idx_nxt   = r_idx;
    w_dec_nxt   = r_dec;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_gt_nxt    = r_gt;
    w_eq_nxt    = r_eq;
    w_lt_nxt    = r_lt;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          // Flipping both sign bits maps two's complement onto unsigned order.
          w_a_nxt     = bus.sgn ? (bus.a ^ SIGN_MASK) : bus.a;
          w_b_nxt     = bus.sgn ? (bus.b ^ SIGN_MASK) : bus.b;
          w_idx_nxt   = IDX_LAST;
          w_dec_nxt   = DEC_NONE;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_dec_nxt = w_dec_step;
        if (w_finish) begin
          w_gt_nxt    = (w_dec_step == DEC_GT);
          w_lt_nxt    = (w_dec_step == DEC_LT);
          w_eq_nxt    = (w_dec_step == DEC_NONE);
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_idx_nxt = r_idx - IDXW'(1);
        end
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_dec   <= DEC_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_idx   <= w_idx_nxt;
      r_dec   <= w_dec_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_gt    <= w_gt_nxt;
      r_eq    <= w_eq_nxt;
      r_lt    <= w_lt_nxt;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.gt   = r_gt;
  assign bus.eq   = r_eq;
  assign bus.lt   = r_lt;

endmodule

// File: doc/comp_seq.md
Name: comp_seq

Overview:
- Parametrised, multi-cycle magnitude comparator; successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands CHUNK bits per cycle, MSB chunk first.
- Supports signed (two's complement) and unsigned mode, selected per operation.
- Uses a start/busy/done handshake so wide compares fit datapaths without a long combinational chain.

Parameters:
- WIDTH, 16, operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of compare steps.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request a compare; accepted only when busy=0.
- sgn  input  1  1 = signed compare, 0 = unsigned; sampled at accept.
- a  input  WIDTH  operand A; sampled at accept.
- b  input  WIDTH  operand B; sampled at accept.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when gt/eq/lt are updated.
- gt  output  1  A > B for the last completed compare.
- eq  output  1  A == B for the last completed compare.
- lt  output  1  A < B for the last completed compare.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - busy=0, done=0, gt=0, eq=0, lt=0, state=IDLE.
  - Reset overrides everything, including an in-flight compare. No done is produced for an aborted compare.
- States: IDLE, RUN.
- IDLE:
  - start=1 at an edge: capture a, b, sgn into internal registers; idx=NCHUNK-1; busy=1; go to RUN.
  - Signed-mode capture: invert bit WIDTH-1 of both captured operands. This maps two's complement onto unsigned order (negative < non-negative).
- RUN, at each edge, compare chunk idx of captured A vs B (unsigned):
  - Chunks differ and no decision yet: record decision (gt or lt). The decision is sticky; later chunks cannot change it.
  - idx==0 (or early exit, see Optional Feature):
    - Drive gt/eq/lt from the decision; eq=1 only if no chunk differed.
    - Pulse done=1 for exactly one cycle; busy=0; go to IDLE.
  - Otherwise idx decrements.
- Outputs:
  - Exactly one of gt/eq/lt is 1 after any completed compare; all three are 0 only after reset.
  - gt/eq/lt are registered and hold until the next done.
- Latency: the accept edge is E. done and the results are visible after edge E+NCHUNK. busy is high for NCHUNK cycles.
- start while busy=1 is ignored. Inputs a/b/sgn may change freely after accept without affecting the result.
- start=1 in the cycle done=1 is accepted (state is IDLE). Back-to-back throughput: one compare per NCHUNK+1 cycles.
- CHUNK==WIDTH: single-step compare; done one cycle after accept.
- Internal registers: captured operands, idx (clog2(NCHUNK) bits, min 1), 2-bit decision. No arithmetic beyond chunk magnitude compare and idx decrement.

Optional Feature:
- Macro: COMP_SEQ_EARLY_TERM_EN.
- Defined: RUN ends on the first differing chunk; done is asserted with the result after that edge. Latency = number of chunks examined (1..NCHUNK). Equal operands still take NCHUNK cycles.
- Undefined: fixed latency of NCHUNK cycles for every compare; results identical.

Test Plan (WIDTH=16, CHUNK=4):
- Unsigned equal: a=0x1234, b=0x1234, sgn=0, start -> done after exactly 4 cycles; eq=1, gt=0, lt=0; busy high 4 cycles.
- Signed vs unsigned: a=0x8000, b=0x0001; sgn=1 -> lt=1; same operands with sgn=0 -> gt=1. Also a=0xFFFF, b=0xFFFE, sgn=1 -> gt=1 (-1 > -2).
- Early exit: a=0xF000, b=0x0FFF, sgn=0 -> gt=1. Latency 1 cycle with COMP_SEQ_EARLY_TERM_EN, 4 cycles without. Same operands LSB-differing (a=0x0001, b=0x0000) -> 4 cycles in both builds.
- Handshake: pulse start with new operands on cycles 2 and 3 after accept -> ignored; result matches the first operands. start held high in the done cycle -> second compare accepted immediately; done pulses 5 cycles apart.
- Reset mid-operation: assert rst_n=0 for 1 cycle two cycles after accept -> next edge gives busy=0, done=0, gt=eq=lt=0. No done follows; a fresh start completes normally.
- Sticky decision: a=0x2F00, b=0x1FFF, sgn=0, early exit disabled -> gt=1 (lower chunks with b>a must not override).
